// File: rtl/cmd_frame_decoder.sv
// Host serial command framer: gathers a command byte plus its fixed-length little-endian
// argument and offers {cmd, arg} on a valid/ready handshake. Optional idle timeout: CMD_TIMEOUT_EN.
module cmd_frame_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Elaboration guard: the timeout counter must be able to reach TIMEOUT_CYCLES-1.
  if (CNT_W < 1 || $clog2(TIMEOUT_CYCLES) > CNT_W) begin : g_cnt_w_check
    $error("cmd_frame_decoder: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  function automatic logic [2:0] arg_len(input logic [7:0] c);
    case (c)
      8'h41:               return 3'd2;
      8'h42:               return 3'd1;
      8'h4F, 8'h4D, 8'h72: return 3'd4;
      default:             return 3'd0;
    endcase
  endfunction

  state_t     state;
  logic [1:0] idx;
  logic [1:0] last_idx;
  logic [2:0] rx_len;
  logic       start_frame;

  assign rx_len = arg_len(rx_data);

  // A byte arriving while the held command is being retired starts a new frame immediately.
  assign start_frame = rx_valid && (state == IDLE || (state == HOLD && cmd_ready));

`ifdef CMD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state != HOLD) && !rx_valid && (idle_cnt == CNT_LIMIT);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      arg       <= '0;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      last_idx  <= '0;
`ifdef CMD_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: ;
        ARG: begin
          if (rx_valid) begin
            arg[{idx, 3'b000} +: 8] <= rx_data;
            idx                     <= idx + 2'd1;
            if (idx == last_idx) begin
              cmd_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= IDLE;
          end else if (rx_valid) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking assignments make the last write in this block win, so the
      // frame-start below deliberately overrides the HOLD retirement above in the same cycle.
      if (start_frame) begin
        cmd <= rx_data;
        arg <= '0;
        if (rx_len == 3'd0) begin
          cmd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= HOLD;
        end else begin
          idx       <= '0;
          last_idx  <= 2'(rx_len - 3'd1);
          busy      <= 1'b1;
          state     <= ARG;
        end
      end

`ifdef CMD_TIMEOUT_EN
      if (state == HOLD || rx_valid) begin
        idle_cnt <= '0;
      end else if (timeout_hit) begin
        // Silence abandons any partial argument and reports the NOP pseudo-command.
        idle_cnt  <= '0;
        cmd       <= 8'hff;
        arg       <= '0;
        cmd_valid <= 1'b1;
        busy      <= 1'b0;
        state     <= HOLD;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed self-checking bench for cmd_frame_decoder; covers the timeout path when CMD_TIMEOUT_EN is defined.
module tb_cmd_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        overrun;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] acc_q[$];

  typedef struct {
    logic [7:0]  c;
    int          len;
    logic [31:0] exp_arg;
  } len_vec_t;

  cmd_frame_decoder #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd      (cmd),
    .arg      (arg),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready) acc_q.push_back({cmd, arg});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    step();
    acc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
    step(); step();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if ({cmd, arg} !== 40'h0) begin n_fail++; $display("FAIL reset_cmd_arg got %h want 0", {cmd, arg}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_arg2();
    do_reset();
    cmd_ready = 1'b1;
    send_byte(8'h41);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL a_busy_after_cmd got %b want 1", busy); end
    send_byte(8'h34);
    n_checks++; if ({busy, cmd_valid} !== 2'b10) begin n_fail++; $display("FAIL a_busy_mid got %b want 10", {busy, cmd_valid}); end
    send_byte(8'h12);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL a_valid_latency got %b want 1", cmd_valid); end
    n_checks++; if ({cmd, arg} !== {8'h41, 32'h00001234}) begin n_fail++; $display("FAIL a_cmd_arg got %h want 4100001234", {cmd, arg}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a_busy_end got %b want 0", busy); end
    step();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL a_valid_drop got %b want 0", cmd_valid); end
    n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL a_accept_count got %0d want 1", acc_q.size()); end
    cmd_ready = 1'b0;
  endtask

  task automatic test_hold();
    int unstable = 0;
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'h4D); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    n_checks++; if ({cmd_valid, cmd, arg} !== {1'b1, 8'h4D, 32'h12345678}) begin n_fail++; $display("FAIL m_frame got %h want 14d12345678", {cmd_valid, cmd, arg}); end
    for (int i = 0; i < 10; i++) begin
      step();
      if ({cmd_valid, cmd, arg} !== {1'b1, 8'h4D, 32'h12345678}) unstable++;
    end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL m_hold_stable got %0d unstable cycles want 0", unstable); end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL m_valid_drop got %b want 0", cmd_valid); end
    n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL m_accept_count got %0d want 1", acc_q.size()); end
    else begin
      n_checks++; if (acc_q[0] !== {8'h4D, 32'h12345678}) begin n_fail++; $display("FAIL m_accepted got %h want 4d12345678", acc_q[0]); end
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL m_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'h63);
    n_checks++; if ({cmd_valid, cmd} !== {1'b1, 8'h63}) begin n_fail++; $display("FAIL o_first got %h want 163", {cmd_valid, cmd}); end
    send_byte(8'h54);
    n_checks++; if ({cmd_valid, cmd, arg} !== {1'b1, 8'h63, 32'h0}) begin n_fail++; $display("FAIL o_cmd_kept got %h want 16300000000", {cmd_valid, cmd, arg}); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL o_overrun_set got %b want 1", overrun); end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step(); step();
    n_checks++; if ({overrun, cmd_valid} !== 2'b10) begin n_fail++; $display("FAIL o_sticky got %b want 10", {overrun, cmd_valid}); end
    n_checks++; if (acc_q.size() !== 1) begin n_fail++; $display("FAIL o_dropped_byte got %0d accepts want 1", acc_q.size()); end
    do_reset();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL o_cleared_by_rst got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_ready = 1'b1;
    rx_data = 8'h63; rx_valid = 1'b1;
    step();
    n_checks++; if ({cmd_valid, cmd} !== {1'b1, 8'h63}) begin n_fail++; $display("FAIL b2b_first got %h want 163", {cmd_valid, cmd}); end
    rx_data = 8'h43;
    step();
    rx_valid = 1'b0;
    n_checks++; if ({cmd_valid, cmd} !== {1'b1, 8'h43}) begin n_fail++; $display("FAIL b2b_second got %h want 143", {cmd_valid, cmd}); end
    step();
    cmd_ready = 1'b0;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", cmd_valid); end
    n_checks++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", acc_q.size()); end
    else begin
      n_checks++; if ({acc_q[0], acc_q[1]} !== {8'h63, 32'h0, 8'h43, 32'h0}) begin n_fail++; $display("FAIL b2b_order got %h want 63000000004300000000", {acc_q[0], acc_q[1]}); end
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_lengths();
    len_vec_t vecs[7] = '{
      '{8'h42, 1, 32'h00000011},
      '{8'h41, 2, 32'h00002211},
      '{8'h4F, 4, 32'h44332211},
      '{8'h72, 4, 32'h44332211},
      '{8'hFF, 0, 32'h00000000},
      '{8'h63, 0, 32'h00000000},
      '{8'h00, 0, 32'h00000000}
    };
    for (int v = 0; v < 7; v++) begin
      int early = 0;
      do_reset();
      cmd_ready = 1'b0;
      send_byte(vecs[v].c);
      for (int k = 0; k < vecs[v].len; k++) begin
        logic [7:0] b;
        if ({busy, cmd_valid} !== 2'b10) early++;
        b = 8'((k + 1) * 17);
        send_byte(b);
      end
      n_checks++; if (early !== 0) begin n_fail++; $display("FAIL len_%h_early got %0d bad cycles want 0", vecs[v].c, early); end
      n_checks++; if ({cmd_valid, busy, cmd, arg} !== {2'b10, vecs[v].c, vecs[v].exp_arg}) begin
        n_fail++; $display("FAIL len_%h_frame got %h want %h", vecs[v].c, {cmd_valid, busy, cmd, arg}, {2'b10, vecs[v].c, vecs[v].exp_arg});
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'h42);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy got %b want 1", busy); end
`ifdef CMD_TIMEOUT_EN
    while (!cmd_valid && n < 40) begin step(); n++; end
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL to_delay got %0d cycles want 16", n); end
    n_checks++; if ({cmd_valid, busy, cmd, arg} !== {2'b10, 8'hFF, 32'h0}) begin n_fail++; $display("FAIL to_pseudo got %h want 2ff00000000", {cmd_valid, busy, cmd, arg}); end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    send_byte(8'h42);
`else
    while (!cmd_valid && n < 40) begin step(); n++; end
    n_checks++; if ({cmd_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL to_waits got %b want 01", {cmd_valid, busy}); end
`endif
    send_byte(8'h5A);
    n_checks++; if ({cmd_valid, cmd, arg} !== {1'b1, 8'h42, 32'h0000005A}) begin n_fail++; $display("FAIL to_next_b got %h want 1420000005a", {cmd_valid, cmd, arg}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_ready = 1'b0;
    send_byte(8'h4F);
    send_byte(8'hAA);
    n_checks++; if ({busy, cmd, arg} !== {1'b1, 8'h4F, 32'h000000AA}) begin n_fail++; $display("FAIL rm_partial got %h want 14f000000aa", {busy, cmd, arg}); end
    rst = 1'b1;
    #1;
    n_checks++; if ({cmd_valid, busy, overrun, cmd, arg} !== 43'h0) begin n_fail++; $display("FAIL rm_async_clear got %h want 0", {cmd_valid, busy, overrun, cmd, arg}); end
    step();
    rst = 1'b0;
    step();
    send_byte(8'h49);
    n_checks++; if ({cmd_valid, busy, cmd, arg} !== {2'b10, 8'h49, 32'h0}) begin n_fail++; $display("FAIL rm_next_cmd got %h want 24900000000", {cmd_valid, busy, cmd, arg}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arg2();
    test_hold();
    test_overrun();
    test_back_to_back();
    test_lengths();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
